rf_access_master: RTL
=====================

// Module: rf_access_master
// PURPOSE
//  Initiator for the 16-bit register file port (register1/register2/data_in/write in,
//  r1_data_out/r2_data_out back). Accepts one request at a time over a valid/ready handshake.
//  Sequences READ2, WRITE and ADDI (read-modify-write, for SP/PCP stepping) onto the port.
//  Returns captured data on a valid/ready response channel. Sits between control FSM and register file.
// PARAMETERS
//  DATA_W   16   register data width
//  ADDR_W   5    register select width
//  MAX_REG  12   highest mapped register index; valid selects are 1..MAX_REG
// PORTS
//  clk          in   1       system clock, all state on posedge
//  reset        in   1       synchronous, active-high reset
//  req_valid    in   1       request present
//  req_ready    out  1       request accepted when req_valid & req_ready at posedge
//  req_op       in   2       00 READ2, 01 WRITE, 10 ADDI, 11 reserved (treated as error)
//  req_ra       in   ADDR_W  register A (read port 1 / write target)
//  req_rb       in   ADDR_W  register B (read port 2; READ2 only)
//  req_wdata    in   DATA_W  WRITE data, or ADDI addend
//  rf_register1 out  ADDR_W  to register file register1 (read A / write select)
//  rf_register2 out  ADDR_W  to register file register2
//  rf_data_in   out  DATA_W  to register file data_in
//  rf_write     out  1       to register file write
//  rf_r1_data   in   DATA_W  from register file r1_data_out
//  rf_r2_data   in   DATA_W  from register file r2_data_out
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumed when rsp_valid & rsp_ready at posedge
//  rsp_a        out  DATA_W  READ2: A data; WRITE: A pre-write value; ADDI: A post-write value
//  rsp_b        out  DATA_W  READ2: B data; else 0
//  rsp_err      out  1       bad select or reserved op; no write performed
// BEHAVIOUR
//  States: IDLE, ACCESS, WB, RESP. Reset -> IDLE.
//  Reset values: rsp_valid=0, rsp_a=0, rsp_b=0, rsp_err=0, rf_write=0, req_ready=0 while reset high.
//  rf_write is gated by !reset: no register-file write in any cycle reset is high, even mid-op.
//  IDLE: req_ready=1; on handshake latch op/ra/rb/wdata, go ACCESS. rf_write=0.
//  ACCESS (1 cycle): rf_register1=ra, rf_register2=rb; capture rf_r1_data->rsp_a, rf_r2_data->rsp_b.
//   err = (op==11) | ra==0 | ra>MAX_REG | (op==READ2 & (rb==0 | rb>MAX_REG)).
//   WRITE & !err: rf_data_in=wdata, rf_write=1 (commits this posedge; rsp_a gets pre-write value).
//   ADDI & !err -> WB; otherwise -> RESP. On err: rsp_a=rsp_b=0, rsp_err=1, rf_write=0.
//  WB (1 cycle): rf_register1=ra, rf_data_in=rsp_a+wdata mod 2^16 (carry dropped), rf_write=1;
//   rsp_a <= sum; -> RESP.
//  RESP: rsp_valid=1, rsp_* stable until rsp_ready; on handshake -> IDLE, rsp_valid=0, rsp_err=0.
//  Latency accept->rsp_valid: READ2/WRITE/err 2 cycles, ADDI 3 cycles. One request outstanding;
//   req_ready=0 in ACCESS/WB/RESP; next accept earliest the cycle after response handshake.
//  rf_register1/2 and rf_data_in are 0 in IDLE and RESP; rf_write asserted only in ACCESS/WB as above.
//  Inputs req_* ignored outside IDLE; rf_r*_data sampled only in ACCESS.
//  Reset mid-operation: state to IDLE next edge, pending write dropped, pending response discarded.
// TESTING
//  After reset, req WRITE ra=3 wdata=0xBEEF -> rf_write=1 one cycle with rf_register1=3; rsp_err=0.
//  READ2 ra=3 rb=5 (reg5=0x0012) -> rsp_valid 2 cycles after accept, rsp_a=0xBEEF, rsp_b=0x0012.
//  ADDI ra=12 (SP=0xFFFE) wdata=0x0003 -> SP=0x0001, rsp_a=0x0001, rsp_valid 3 cycles after accept.
//  WRITE ra=0, ra=13, and op=11 -> rsp_err=1, rsp_a=rsp_b=0, rf_write never asserted.
//  Hold rsp_ready=0 for 5 cycles -> rsp_* stable, req_ready=0; release -> IDLE, req_ready=1 next cycle.
//  Assert reset during WB of ADDI -> rf_write=0 that cycle, target unchanged, rsp_valid stays 0.

Source files
------------

// File: rtl/rf_access_master.sv
// Register-file access initiator: sequences READ2, WRITE and ADDI (read-modify-write)
// requests onto a 16-bit register-file port and returns results over a valid/ready channel.
module rf_access_master #(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 5,
    parameter int MAX_REG = 12
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic [1:0]        req_op,
    input  logic [ADDR_W-1:0] req_ra,
    input  logic [ADDR_W-1:0] req_rb,
    input  logic [DATA_W-1:0] req_wdata,

    output logic [ADDR_W-1:0] rf_register1,
    output logic [ADDR_W-1:0] rf_register2,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              rf_write,
    input  logic [DATA_W-1:0] rf_r1_data,
    input  logic [DATA_W-1:0] rf_r2_data,

    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              rsp_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WB,
        RESP
    } state_t;

    localparam logic [1:0]        OP_READ2 = 2'b00;
    localparam logic [1:0]        OP_WRITE = 2'b01;
    localparam logic [1:0]        OP_ADDI  = 2'b10;
    localparam logic [1:0]        OP_RSVD  = 2'b11;
    localparam logic [ADDR_W-1:0] MAX_SEL  = ADDR_W'(MAX_REG);

    state_t              state;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   ra_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                err_q;
    logic                ready_q;
    logic                write_q;
    logic                req_err;

    function automatic logic sel_bad(input logic [ADDR_W-1:0] sel);
        return (sel == '0) || (sel > MAX_SEL);
    endfunction

    // Errors are resolved at accept time so the ACCESS cycle only has to act on one flag.
    assign req_err = (req_op == OP_RSVD) || sel_bad(req_ra) ||
                     ((req_op == OP_READ2) && sel_bad(req_rb));

    // NOTE: reset is also gated combinationally so that a write already set up for this
    // cycle is suppressed the moment reset rises, not one edge later.
    assign req_ready = ready_q & ~reset;
    assign rf_write  = write_q & ~reset;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            op_q         <= OP_READ2;
            ra_q         <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            ready_q      <= 1'b0;
            write_q      <= 1'b0;
            rf_register1 <= '0;
            rf_register2 <= '0;
            rf_data_in   <= '0;
            rsp_valid    <= 1'b0;
            rsp_a        <= '0;
            rsp_b        <= '0;
            rsp_err      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (req_valid && ready_q) begin
                        state        <= ACCESS;
                        ready_q      <= 1'b0;
                        op_q         <= req_op;
                        ra_q         <= req_ra;
                        wdata_q      <= req_wdata;
                        err_q        <= req_err;
                        rf_register1 <= req_ra;
                        rf_register2 <= req_rb;
                        if ((req_op == OP_WRITE) && !req_err) begin
                            rf_data_in <= req_wdata;
                            write_q    <= 1'b1;
                        end
                    end
                end

                ACCESS: begin
                    write_q      <= 1'b0;
                    rf_register2 <= '0;
                    rf_data_in   <= '0;
                    if (err_q) begin
                        rsp_a        <= '0;
                        rsp_b        <= '0;
                        rsp_err      <= 1'b1;
                        rsp_valid    <= 1'b1;
                        rf_register1 <= '0;
                        state        <= RESP;
                    end else begin
                        // WRITE commits on this same edge, so rsp_a holds the pre-write value.
                        rsp_a <= rf_r1_data;
                        rsp_b <= (op_q == OP_READ2) ? rf_r2_data : '0;
                        if (op_q == OP_ADDI) begin
                            rf_register1 <= ra_q;
                            rf_data_in   <= rf_r1_data + wdata_q;
                            write_q      <= 1'b1;
                            state        <= WB;
                        end else begin
                            rf_register1 <= '0;
                            rsp_valid    <= 1'b1;
                            state        <= RESP;
                        end
                    end
                end

                WB: begin
                    rsp_a        <= rf_data_in;
                    write_q      <= 1'b0;
                    rf_register1 <= '0;
                    rf_data_in   <= '0;
                    rsp_valid    <= 1'b1;
                    state        <= RESP;
                end

                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        ready_q   <= 1'b1;
                        state     <= IDLE;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
